// File: rtl/if_id_pkg.sv
// Shared types and helpers for the IF/ID skid stage.
package if_id_pkg;

  // Occupancy states of the two-entry skid buffer
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MAIN  = 2'd1,
    BOTH  = 2'd2
  } state_e;

  // sll $0,$0,0
  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

  // Flat bundle width: per lane instruction + PC + lane valid
  function automatic int unsigned bundle_w(input int unsigned lanes,
                                           input int unsigned instr_w,
                                           input int unsigned pc_w);
    return lanes * (instr_w + pc_w + 1);
  endfunction

endpackage

// File: rtl/if_id_lane_mask.sv
// Per-lane NOP substitution for invalid slots.
module if_id_lane_mask
  import if_id_pkg::*;
#(
  parameter int unsigned          INSTR_W  = 32,
  parameter logic [INSTR_W-1:0]   NOP_WORD = INSTR_W'(MIPS_NOP)
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic               lane_vld,
  output logic [INSTR_W-1:0] instr_c
);

  // Pass the slot through only when it carries a live instruction
  assign instr_c = lane_vld ? instr : NOP_WORD;

endmodule

// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline stage with valid/ready handshake and 2-entry skid buffer.
module if_id_skid_stage
  import if_id_pkg::*;
#(
  parameter int unsigned        LANES    = 1,
  parameter int unsigned        INSTR_W  = 32,
  parameter int unsigned        PC_W     = 32,
  parameter logic [INSTR_W-1:0] NOP_WORD = INSTR_W'(MIPS_NOP),
  parameter int unsigned        CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*INSTR_W-1:0] in_instr,
  input  logic [LANES*PC_W-1:0]    in_pc,
  input  logic [LANES-1:0]         in_lane_vld,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*INSTR_W-1:0] out_instr,
  output logic [LANES*PC_W-1:0]    out_pc,
  output logic [LANES-1:0]         out_lane_vld,
  output logic [1:0]               occupancy,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam int unsigned IW = LANES * INSTR_W;
  localparam int unsigned PW = LANES * PC_W;
  localparam int unsigned BW = bundle_w(LANES, INSTR_W, PC_W);

  state_e          state_q, state_d;
  logic            in_ready_q, out_valid_q;
  logic [1:0]      occ_q, occ_d;
  logic [CNT_W-1:0] stall_q;
  logic [BW-1:0]   in_bundle, main_q, skid_q;
  logic            store, drn;
  logic            ld_main_in, ld_main_skid, ld_skid, clr_main;

  // Bundles with no live lane are accepted but never occupy an entry
  assign in_bundle = {in_lane_vld, in_pc, in_instr};
  assign store     = in_valid & in_ready_q & (|in_lane_vld);
  assign drn       = out_valid_q & out_ready;

  // State register plus registered handshake/occupancy outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != BOTH);
      out_valid_q <= (state_d != EMPTY);
      occ_q       <= occ_d;
    end
  end

  // Next state and entry load controls; flush overrides everything
  always_comb begin
    state_d      = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    clr_main     = 1'b0;
    case (state_q)
      EMPTY: begin
        if (store) begin
          state_d    = MAIN;
          ld_main_in = 1'b1;
        end
      end
      MAIN: begin
        if (store && drn) begin
          ld_main_in = 1'b1;
        end else if (store) begin
          state_d = BOTH;
          ld_skid = 1'b1;
        end else if (drn) begin
          state_d  = EMPTY;
          clr_main = 1'b1;
        end
      end
      BOTH: begin
        if (drn) begin
          state_d      = MAIN;
          ld_main_skid = 1'b1;
        end
      end
      default: begin
        state_d  = EMPTY;
        clr_main = 1'b1;
      end
    endcase
    if (flush_i) begin
      state_d      = EMPTY;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      clr_main     = 1'b1;
    end
  end

  // Entry count for the upcoming state
  always_comb begin
    occ_d = 2'd0;
    case (state_d)
      MAIN:    occ_d = 2'd1;
      BOTH:    occ_d = 2'd2;
      default: occ_d = 2'd0;
    endcase
  end

  // Main/skid bundle storage; main is cleared when empty so PC and lane valid read 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (clr_main)          main_q <= '0;
      else if (ld_main_in)   main_q <= in_bundle;
      else if (ld_main_skid) main_q <= skid_q;
      if (ld_skid)           skid_q <= in_bundle;
    end
  end

  // Saturating back-pressure counter, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (out_valid_q && !out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign occupancy    = occ_q;
  assign stall_cnt    = stall_q;
  assign out_pc       = main_q[IW +: PW];
  assign out_lane_vld = main_q[IW+PW +: LANES];

  // NOP substitution per lane on the held bundle
  for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
    if_id_lane_mask #(
      .INSTR_W  (INSTR_W),
      .NOP_WORD (NOP_WORD)
    ) u_mask (
      .instr    (main_q[g*INSTR_W +: INSTR_W]),
      .lane_vld (out_valid_q & main_q[IW+PW+g]),
      .instr_c  (out_instr[g*INSTR_W +: INSTR_W])
    );
  end

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed bench: single-lane instance (default params) and a 2-lane, 4-bit counter instance.
module tb_if_id_skid_stage;

  logic clk;
  logic rst_n;

  // Instance A: LANES=1, CNT_W=16, NOP_WORD default
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_instr, a_in_pc, a_out_instr, a_out_pc;
  logic [0:0]  a_in_lv, a_out_lv;
  logic [1:0]  a_occ;
  logic [15:0] a_stall;

  // Instance B: LANES=2, CNT_W=4, distinctive NOP_WORD
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [63:0] b_in_instr, b_in_pc, b_out_instr, b_out_pc;
  logic [1:0]  b_in_lv, b_out_lv;
  logic [1:0]  b_occ;
  logic [3:0]  b_stall;

  int n_cmp;
  int n_err;

  if_id_skid_stage u_dut_a (
    .clk(clk), .rst_n(rst_n), .flush_i(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_instr(a_in_instr), .in_pc(a_in_pc), .in_lane_vld(a_in_lv),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_instr(a_out_instr), .out_pc(a_out_pc), .out_lane_vld(a_out_lv),
    .occupancy(a_occ), .stall_cnt(a_stall)
  );

  if_id_skid_stage #(
    .LANES(2), .INSTR_W(32), .PC_W(32), .NOP_WORD(32'hDEAD_BEEF), .CNT_W(4)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .flush_i(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_instr(b_in_instr), .in_pc(b_in_pc), .in_lane_vld(b_in_lv),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_instr(b_out_instr), .out_pc(b_out_pc), .out_lane_vld(b_out_lv),
    .occupancy(b_occ), .stall_cnt(b_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    a_in_valid = v;
    a_in_instr = instr;
    a_in_pc    = pc;
    a_in_lv    = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    a_in_instr = '0; a_in_pc = '0; a_in_lv = '0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    b_in_instr = '0; b_in_pc = '0; b_in_lv = '0;
    step();
    step();

    // Reset values
    check("rst_in_ready",  64'(a_in_ready),  64'd1);
    check("rst_out_valid", 64'(a_out_valid), 64'd0);
    check("rst_out_instr", 64'(a_out_instr), 64'd0);
    check("rst_out_pc",    64'(a_out_pc),    64'd0);
    check("rst_lane_vld",  64'(a_out_lv),    64'd0);
    check("rst_occ",       64'(a_occ),       64'd0);
    check("rst_stall",     64'(a_stall),     64'd0);
    check("rst_b_instr",   b_out_instr,      64'hDEADBEEF_DEADBEEF);
    rst_n = 1'b1;

    // Single bundle, 1-cycle latency
    a_out_ready = 1'b1;
    a_drive(1'b1, 32'h8C08_0004, 32'h0000_0004);
    step();
    check("lat_valid",    64'(a_out_valid), 64'd1);
    check("lat_instr",    64'(a_out_instr), 64'h8C08_0004);
    check("lat_pc",       64'(a_out_pc),    64'h4);
    check("lat_in_ready", 64'(a_in_ready),  64'd1);
    check("lat_occ",      64'(a_occ),       64'd1);
    a_in_valid = 1'b0;
    step();
    check("drain_valid", 64'(a_out_valid), 64'd0);
    check("drain_instr", 64'(a_out_instr), 64'd0);
    check("drain_pc",    64'(a_out_pc),    64'd0);
    check("drain_occ",   64'(a_occ),       64'd0);

    // Back-pressure: A in main, B in skid, C held off
    a_out_ready = 1'b0;
    a_drive(1'b1, 32'hA000_0001, 32'h100);
    step();
    check("bp_a_instr", 64'(a_out_instr), 64'hA000_0001);
    check("bp_a_ready", 64'(a_in_ready),  64'd1);
    check("bp_a_stall", 64'(a_stall),     64'd0);
    a_drive(1'b1, 32'hA000_0002, 32'h104);
    step();
    check("bp_b_occ",   64'(a_occ),       64'd2);
    check("bp_b_ready", 64'(a_in_ready),  64'd0);
    check("bp_b_instr", 64'(a_out_instr), 64'hA000_0001);
    check("bp_b_stall", 64'(a_stall),     64'd1);
    a_drive(1'b1, 32'hA000_0003, 32'h108);
    step();
    step();
    check("bp_c_occ",   64'(a_occ),   64'd2);
    check("bp_c_stall", 64'(a_stall), 64'd3);
    a_out_ready = 1'b1;
    step();
    check("bp_out_b",     64'(a_out_instr), 64'hA000_0002);
    check("bp_out_b_pc",  64'(a_out_pc),    64'h104);
    check("bp_out_b_occ", 64'(a_occ),       64'd1);
    check("bp_out_b_rdy", 64'(a_in_ready),  64'd1);
    step();
    check("bp_out_c",    64'(a_out_instr), 64'hA000_0003);
    check("bp_out_c_pc", 64'(a_out_pc),    64'h108);
    a_in_valid = 1'b0;
    step();
    check("bp_end_valid", 64'(a_out_valid), 64'd0);
    check("bp_end_stall", 64'(a_stall),     64'd3);

    // Flush while BOTH with D presented
    a_out_ready = 1'b0;
    a_drive(1'b1, 32'hE000_0001, 32'h200);
    step();
    a_drive(1'b1, 32'hE000_0002, 32'h204);
    step();
    check("fl_both_occ", 64'(a_occ), 64'd2);
    a_flush = 1'b1;
    a_drive(1'b1, 32'hD000_000D, 32'h300);
    step();
    check("fl_valid", 64'(a_out_valid), 64'd0);
    check("fl_instr", 64'(a_out_instr), 64'd0);
    check("fl_occ",   64'(a_occ),       64'd0);
    check("fl_ready", 64'(a_in_ready),  64'd1);
    check("fl_stall", 64'(a_stall),     64'd5);
    a_flush = 1'b0;
    a_in_valid = 1'b0;
    step();
    check("fl_no_d", 64'(a_out_valid), 64'd0);

    // Flush in MAIN with D accepted the same cycle
    a_drive(1'b1, 32'hF000_0001, 32'h400);
    step();
    a_flush = 1'b1;
    a_drive(1'b1, 32'hD000_000D, 32'h300);
    step();
    check("flm_valid", 64'(a_out_valid), 64'd0);
    check("flm_stall", 64'(a_stall),     64'd6);
    a_flush = 1'b0;
    a_in_valid = 1'b0;
    step();
    check("flm_no_d", 64'(a_out_valid), 64'd0);

    // Bundle with no valid lane is swallowed
    a_out_ready = 1'b1;
    a_drive(1'b1, 32'h1234_5678, 32'h500);
    a_in_lv = 1'b0;
    step();
    check("emp_valid", 64'(a_out_valid), 64'd0);
    check("emp_occ",   64'(a_occ),       64'd0);
    a_in_valid = 1'b0;

    // Async reset while BOTH, checked before the next edge
    a_out_ready = 1'b0;
    a_drive(1'b1, 32'h9000_0001, 32'h600);
    step();
    a_drive(1'b1, 32'h9000_0002, 32'h604);
    step();
    check("ar_pre_occ",   64'(a_occ),   64'd2);
    check("ar_pre_stall", 64'(a_stall), 64'd7);
    a_in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 64'(a_out_valid), 64'd0);
    check("ar_instr", 64'(a_out_instr), 64'd0);
    check("ar_pc",    64'(a_out_pc),    64'd0);
    check("ar_occ",   64'(a_occ),       64'd0);
    check("ar_ready", 64'(a_in_ready),  64'd1);
    check("ar_stall", 64'(a_stall),     64'd0);
    step();
    rst_n = 1'b1;
    step();

    // Two lanes, only lane 0 valid
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1;
    b_in_lv     = 2'b01;
    b_in_instr  = 64'h01095020_8C080004;
    b_in_pc     = 64'h00000008_00000004;
    step();
    check("ln_instr", b_out_instr,     64'hDEADBEEF_8C080004);
    check("ln_pc",    b_out_pc,        64'h00000008_00000004);
    check("ln_vld",   64'(b_out_lv),   64'd1);
    b_in_valid = 1'b0;

    // Saturating 4-bit stall counter
    repeat (15) step();
    check("sat_15", 64'(b_stall), 64'd15);
    repeat (5) step();
    check("sat_20", 64'(b_stall), 64'd15);

    // Both lanes valid through skid
    b_in_valid = 1'b1;
    b_in_lv    = 2'b11;
    b_in_instr = 64'h11111111_22222222;
    b_in_pc    = 64'h00000010_0000000C;
    step();
    check("b2_occ", 64'(b_occ), 64'd2);
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    step();
    check("b2_instr", b_out_instr,   64'h11111111_22222222);
    check("b2_pc",    b_out_pc,      64'h00000010_0000000C);
    check("b2_vld",   64'(b_out_lv), 64'd3);
    check("b2_occ1",  64'(b_occ),    64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
